// File: rtl/if_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_if
// Description : Fetch-stage bundle. Carries the stall vector and the decode
//               redirect in, and the {ce, pc} word and SRAM request out.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_if;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;

  modport master (
    input  stall,
    input  br_bus,
    output if_to_id_bus,
    output inst_sram_en,
    output inst_sram_wen,
    output inst_sram_addr,
    output inst_sram_wdata
  );

  modport slave (
    output stall,
    output br_bus,
    input  if_to_id_bus,
    input  inst_sram_en,
    input  inst_sram_wen,
    input  inst_sram_addr,
    input  inst_sram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : MIPS instruction-fetch stage. Owns the PC, drives the
//               instruction SRAM, and remembers a redirect seen while stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch (
  input  wire logic   clk,
  input  wire logic   rst,
  if_fetch_if.master  bus
);

  localparam logic [31:0] c_reset_pc = 32'hbfbf_fffc;
  localparam logic [31:0] c_pc_step  = 32'd4;
  localparam logic        c_stop     = 1'b1;

  logic [31:0] pc_reg;
  logic        ce_reg;
  logic        pend_v;
  logic [31:0] pend_addr;
  logic [31:0] w_next_pc;
  logic        w_br_e;
  logic [31:0] w_br_addr;
  logic        w_stall_pc;
  logic        w_unused_stall;

  assign w_br_e         = bus.br_bus[32];
  assign w_br_addr      = bus.br_bus[31:0];
  assign w_stall_pc     = bus.stall[0];
  // Only the fetch bit of the stall vector matters here.
  assign w_unused_stall = ^bus.stall[5:1];

  always_comb begin
    w_next_pc = pc_reg + c_pc_step;
    if (w_br_e) begin
      w_next_pc = w_br_addr;
    end else if (pend_v) begin
      w_next_pc = pend_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= c_reset_pc;
      ce_reg    <= 1'b0;
      pend_v    <= 1'b0;
      pend_addr <= 32'h0;
    end else if (w_stall_pc != c_stop) begin
      pc_reg <= w_next_pc;
      ce_reg <= 1'b1;
      pend_v <= 1'b0;
    end else if (w_br_e) begin
      // Held redirect; a later one in the same stall replaces it.
      pend_v    <= 1'b1;
      pend_addr <= w_br_addr;
    end
  end

  assign bus.if_to_id_bus    = {ce_reg, pc_reg};
  assign bus.inst_sram_en    = ce_reg;
  assign bus.inst_sram_wen   = 4'b0000;
  assign bus.inst_sram_addr  = pc_reg;
  assign bus.inst_sram_wdata = 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch
// Description : Directed self-checking bench for the if_fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  if_fetch_if bus ();

  if_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic stall0, input logic br_e, input logic [31:0] br_addr);
    bus.stall  = {5'b0, stall0};
    bus.br_bus = {br_e, br_addr};
  endtask

  task automatic reset_and_run(input int cycles);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    step();
    step();
    total++;
    if (bus.if_to_id_bus !== {1'b0, 32'hbfbf_fffc})
      $display("FAIL reset_bus: got %h expected %h", bus.if_to_id_bus, {1'b0, 32'hbfbf_fffc});
    else passed++;
    total++;
    if ({bus.inst_sram_en, bus.inst_sram_wen, bus.inst_sram_wdata} !== 37'h0)
      $display("FAIL reset_sram_ctl: got en=%b wen=%h wdata=%h expected all zero",
               bus.inst_sram_en, bus.inst_sram_wen, bus.inst_sram_wdata);
    else passed++;
    total++;
    if (bus.inst_sram_addr !== 32'hbfbf_fffc)
      $display("FAIL reset_addr: got %h expected bfbffffc", bus.inst_sram_addr);
    else passed++;
    rst = 1'b0;
    exp_pc = 32'hbfc0_0000;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (bus.if_to_id_bus !== {1'b1, exp_pc} || bus.inst_sram_en !== 1'b1 ||
          bus.inst_sram_addr !== exp_pc)
        $display("FAIL free_run_%0d: got bus=%h en=%b addr=%h expected bus=%h en=1",
                 i, bus.if_to_id_bus, bus.inst_sram_en, bus.inst_sram_addr, {1'b1, exp_pc});
      else passed++;
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_redirect();
    reset_and_run(3);
    total++;
    if (bus.inst_sram_addr !== 32'hbfc0_0008)
      $display("FAIL redir_setup: got %h expected bfc00008", bus.inst_sram_addr);
    else passed++;
    drive(1'b0, 1'b1, 32'hbfc0_0100);
    step();
    total++;
    if (bus.if_to_id_bus !== {1'b1, 32'hbfc0_0100})
      $display("FAIL redir_target: got %h expected %h", bus.if_to_id_bus, {1'b1, 32'hbfc0_0100});
    else passed++;
    drive(1'b0, 1'b0, 32'h0);
    step();
    total++;
    if (bus.inst_sram_addr !== 32'hbfc0_0104)
      $display("FAIL redir_next: got %h expected bfc00104", bus.inst_sram_addr);
    else passed++;
  endtask

  task automatic test_stall_redirect();
    reset_and_run(5);
    total++;
    if (bus.inst_sram_addr !== 32'hbfc0_0010)
      $display("FAIL stall_setup: got %h expected bfc00010", bus.inst_sram_addr);
    else passed++;
    drive(1'b1, 1'b1, 32'hbfc0_0200);
    step();
    drive(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.inst_sram_addr !== 32'hbfc0_0010 || dut.pend_v !== 1'b1 || bus.inst_sram_en !== 1'b1)
        $display("FAIL stall_hold_%0d: got addr=%h pend_v=%b en=%b expected bfc00010 1 1",
                 i, bus.inst_sram_addr, dut.pend_v, bus.inst_sram_en);
      else passed++;
      if (i < 2) step();
    end
    drive(1'b0, 1'b0, 32'h0);
    step();
    total++;
    if (bus.inst_sram_addr !== 32'hbfc0_0200 || dut.pend_v !== 1'b0)
      $display("FAIL stall_release: got addr=%h pend_v=%b expected bfc00200 0",
               bus.inst_sram_addr, dut.pend_v);
    else passed++;
    step();
    total++;
    if (bus.inst_sram_addr !== 32'hbfc0_0204)
      $display("FAIL stall_after: got %h expected bfc00204", bus.inst_sram_addr);
    else passed++;
  endtask

  task automatic test_two_redirects();
    logic [31:0] held;
    held = bus.inst_sram_addr;
    drive(1'b1, 1'b1, 32'hbfc0_0300);
    step();
    drive(1'b1, 1'b1, 32'hbfc0_0400);
    step();
    total++;
    if (bus.inst_sram_addr !== held)
      $display("FAIL two_hold: got %h expected %h", bus.inst_sram_addr, held);
    else passed++;
    drive(1'b0, 1'b0, 32'h0);
    step();
    total++;
    if (bus.inst_sram_addr !== 32'hbfc0_0400)
      $display("FAIL two_last_wins: got %h expected bfc00400", bus.inst_sram_addr);
    else passed++;
    // Pending target set, then a fresh branch arrives on the release cycle.
    drive(1'b1, 1'b1, 32'hbfc0_0500);
    step();
    drive(1'b0, 1'b1, 32'hbfc0_0600);
    step();
    total++;
    if (bus.inst_sram_addr !== 32'hbfc0_0600 || dut.pend_v !== 1'b0)
      $display("FAIL release_with_branch: got addr=%h pend_v=%b expected bfc00600 0",
               bus.inst_sram_addr, dut.pend_v);
    else passed++;
    drive(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 32'hffff_fffc);
    step();
    total++;
    if (bus.inst_sram_addr !== 32'hffff_fffc)
      $display("FAIL wrap_target: got %h expected fffffffc", bus.inst_sram_addr);
    else passed++;
    drive(1'b0, 1'b0, 32'h0);
    step();
    total++;
    if (bus.if_to_id_bus !== {1'b1, 32'h0000_0000})
      $display("FAIL wrap_zero: got %h expected %h", bus.if_to_id_bus, {1'b1, 32'h0});
    else passed++;
    total++;
    if ((^{bus.if_to_id_bus, bus.inst_sram_en, bus.inst_sram_wen,
           bus.inst_sram_addr, bus.inst_sram_wdata}) === 1'bx)
      $display("FAIL wrap_no_x: got X on outputs expected known values");
    else passed++;
  endtask

  task automatic test_reset_pending();
    drive(1'b1, 1'b1, 32'hbfc0_0700);
    step();
    total++;
    if (dut.pend_v !== 1'b1)
      $display("FAIL rstpend_setup: got pend_v=%b expected 1", dut.pend_v);
    else passed++;
    drive(1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    step();
    total++;
    if (bus.if_to_id_bus !== {1'b0, 32'hbfbf_fffc} || dut.pend_v !== 1'b0)
      $display("FAIL rstpend_reset: got bus=%h pend_v=%b expected %h 0",
               bus.if_to_id_bus, dut.pend_v, {1'b0, 32'hbfbf_fffc});
    else passed++;
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    step();
    total++;
    if (bus.if_to_id_bus !== {1'b1, 32'hbfc0_0000})
      $display("FAIL rstpend_first_fetch: got %h expected %h",
               bus.if_to_id_bus, {1'b1, 32'hbfc0_0000});
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    test_reset();
    test_redirect();
    test_stall_redirect();
    test_two_redirects();
    test_wrap();
    test_reset_pending();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
